// File: rtl/comparator_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
// The result encoding matches the combinational comparator: {gt, eq, lt}.
package comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    localparam int C_GT = 2;
    localparam int C_EQ = 1;
    localparam int C_LT = 0;

    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/comparator_serial_digit_compare.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module digit_compare #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             gt,
    output logic             lt
);

    assign gt = (x > y);
    assign lt = (x < y);

endmodule

// File: rtl/comparator_serial.sv
// Digit-serial magnitude comparator: walks both operands MSB-first, DIGIT bits
// per cycle, and stops at the first differing digit.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2:0]       c
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("comparator_serial: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sa_nx;
    logic [WIDTH-1:0] sb, sb_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [2:0]       c_nx;
    logic             done_nx;
    logic             dig_gt, dig_lt;

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .x  (sa[WIDTH-1 -: DIGIT]),
        .y  (sb[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            c     <= RES_NONE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            sa    <= sa_nx;
            sb    <= sb_nx;
            cnt   <= cnt_nx;
            c     <= c_nx;
            done  <= done_nx;
        end
    end

    // Flipping the MSB maps two's complement onto offset binary, so the
    // datapath only ever needs an unsigned digit compare.
    always_comb begin
        state_nx = state;
        sa_nx    = sa;
        sb_nx    = sb;
        cnt_nx   = cnt;
        c_nx     = c;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sa_nx    = signed_mode ? (a ^ MSB_MASK) : a;
                    sb_nx    = signed_mode ? (b ^ MSB_MASK) : b;
                    cnt_nx   = CW'(NDIG - 1);
                    state_nx = CMP;
                end
            end
            CMP: begin
                if (dig_gt) begin
                    c_nx     = RES_GT;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (dig_lt) begin
                    c_nx     = RES_LT;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == '0) begin
                    c_nx     = RES_EQ;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    sa_nx  = sa << DIGIT;
                    sb_nx  = sb << DIGIT;
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == CMP);

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench for comparator_serial: 8-bit/2-bit vector table, handshake and
// reset sequences, plus exhaustive 2-bit checks at DIGIT=1 and DIGIT=2.
module tb_comparator_serial;
    import comparator_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit, 2-bit digit instance
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done;
    logic [2:0] c;

    // 2-bit instances sharing stimulus
    logic       s_start = 1'b0;
    logic       s_sm = 1'b0;
    logic [1:0] s_a = '0;
    logic [1:0] s_b = '0;
    logic       busy1, done1, busy2, done2;
    logic [2:0] c1, c2;

    comparator_serial #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .c(c)
    );

    comparator_serial #(.WIDTH(2), .DIGIT(1)) dut_w2d1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .signed_mode(s_sm),
        .a(s_a), .b(s_b), .busy(busy1), .done(done1), .c(c1)
    );

    comparator_serial #(.WIDTH(2), .DIGIT(2)) dut_w2d2 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .signed_mode(s_sm),
        .a(s_a), .b(s_b), .busy(busy2), .done(done2), .c(c2)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drives start for one edge (edge 0); returns #1 after that edge.
    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                          input logic [2:0] exp_c, input bit push);
        a = av;
        b = bv;
        signed_mode = sm;
        start = 1'b1;
        if (push) exp_q.push_back(exp_c);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        signed_mode = 1'($urandom_range(0, 1));
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Counts edges after the current one until done; returns #1 after the done edge.
    task automatic wait_done(input string name, input int exp_lat);
        int lat;
        logic [2:0] exp_c;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : RES_NONE;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_c"}, 32'(c), 32'(exp_c));
        check({name, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [2:0] exp_c;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int extra;
        vecs[0] = '{8'hA5, 8'hA5, 1'b0, RES_EQ, 4};
        vecs[1] = '{8'h80, 8'h7F, 1'b0, RES_GT, 1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, RES_LT, 1};
        vecs[3] = '{8'h12, 8'h13, 1'b0, RES_LT, 4};
        vecs[4] = '{8'hFE, 8'hFF, 1'b1, RES_LT, 4};
        vecs[5] = '{8'h01, 8'h00, 1'b0, RES_GT, 4};
        vecs[6] = '{8'h30, 8'h20, 1'b0, RES_GT, 2};
        vecs[7] = '{8'hFF, 8'h00, 1'b1, RES_LT, 1};
        vecs[8] = '{8'h04, 8'h08, 1'b0, RES_LT, 3};
        vecs[9] = '{8'h81, 8'h81, 1'b1, RES_EQ, 4};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_c", 32'(c), 32'(RES_NONE));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_c_w2d1", 32'(c1), 32'(RES_NONE));
        check("reset_c_w2d2", 32'(c2), 32'(RES_NONE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp_c, 1'b1);
            wait_done($sformatf("vec%0d", i), vecs[i].exp_lat);
        end

        // start while busy is ignored and not queued
        launch(8'h12, 8'h13, 1'b0, RES_LT, 1'b1);
        a = 8'hFF;
        b = 8'h00;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_start", 3);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("no_queued_start", 32'(extra), 32'd0);

        // back-to-back: start presented in the done cycle
        launch(8'h80, 8'h7F, 1'b1, RES_LT, 1'b1);
        wait_done("b2b_first", 1);
        launch(8'h01, 8'h00, 1'b0, RES_GT, 1'b1);
        wait_done("b2b_second", 4);

        // asynchronous reset in cycle 2 of an equal-operand compare
        launch(8'hA5, 8'hA5, 1'b0, RES_EQ, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_c", 32'(c), 32'(RES_NONE));
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("no_done_after_reset", 32'(extra), 32'd0);
        launch(8'h30, 8'h20, 1'b0, RES_GT, 1'b1);
        wait_done("post_reset", 2);

        // exhaustive 2-bit checks against a reference model
        for (int sm = 0; sm < 2; sm++) begin
            for (int x = 0; x < 4; x++) begin
                for (int y = 0; y < 4; y++) begin
                    int lat1, lat2, vx, vy, mx, my, elat1;
                    logic [2:0] cc1, cc2, ec;
                    string tag;
                    lat1 = -1;
                    lat2 = -1;
                    cc1 = '0;
                    cc2 = '0;
                    s_a = 2'(x);
                    s_b = 2'(y);
                    s_sm = 1'(sm);
                    s_start = 1'b1;
                    @(posedge clk);
                    #1;
                    s_start = 1'b0;
                    s_a = 2'($urandom);
                    s_b = 2'($urandom);
                    for (int k = 1; k <= 6; k++) begin
                        @(posedge clk);
                        #1;
                        if (done1 && lat1 < 0) begin lat1 = k; cc1 = c1; end
                        if (done2 && lat2 < 0) begin lat2 = k; cc2 = c2; end
                        if (lat1 > 0 && lat2 > 0) break;
                    end
                    vx = (sm == 1 && x >= 2) ? x - 4 : x;
                    vy = (sm == 1 && y >= 2) ? y - 4 : y;
                    ec = (vx > vy) ? RES_GT : (vx < vy) ? RES_LT : RES_EQ;
                    mx = (sm == 1) ? (x ^ 2) : x;
                    my = (sm == 1) ? (y ^ 2) : y;
                    elat1 = ((mx >> 1) != (my >> 1)) ? 1 : 2;
                    tag = $sformatf("ex_s%0d_a%0d_b%0d", sm, x, y);
                    check({tag, "_w2d1_c"}, 32'(cc1), 32'(ec));
                    check({tag, "_w2d1_lat"}, 32'(lat1), 32'(elat1));
                    check({tag, "_w2d2_c"}, 32'(cc2), 32'(ec));
                    check({tag, "_w2d2_lat"}, 32'(lat2), 32'd1);
                end
            end
        end

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/comparator_serial.md
# comparator_serial

Parametrised, digit-serial magnitude comparator with selectable signed or unsigned mode and a start/busy/done handshake. It compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle. Once a digit differs, it stops early and reports greater, equal or less on the same 3-bit result encoding as the combinational 2-bit comparator. It sits between operand producers and control logic wherever a full-width parallel compare is too costly in area.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; must be at least 1.
- DIGIT, 2: bits compared per cycle; must divide WIDTH exactly (elaboration-time check).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request a compare; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when c is updated.
- c  output  3  result, {a_gt_b, a_eq_b, a_lt_b}; exactly one bit is set after the first compare.

## Operation
- States:
  - IDLE: busy=0.
  - CMP: busy=1.
- IDLE with start=1 at a clock edge:
  - latch a and b into shift registers sa and sb;
  - if signed_mode=1, invert the MSB of both latched operands (offset-binary mapping; signed order becomes unsigned order);
  - load digit counter with WIDTH/DIGIT-1;
  - go to CMP.
- CMP, each cycle: compare the top DIGIT bits of sa and sb as unsigned.
  - Top digit of sa > top digit of sb: c<=3'b100, done<=1, go to IDLE.
  - Top digit of sa < top digit of sb: c<=3'b001, done<=1, go to IDLE.
  - Digits equal and counter=0: c<=3'b010, done<=1, go to IDLE.
  - Digits equal and counter>0: shift sa and sb left by DIGIT, decrement counter, stay in CMP.
- start while busy=1 is ignored; no queueing.
- c holds its last result until the next done; it is never cleared by a new start.
- Inputs a, b and signed_mode may change freely after the start edge.
- Reset (rst_n low, any time, including mid-compare):
  - state=IDLE;
  - busy=0, done=0, c=3'b000;
  - the in-flight compare is discarded and no done is issued.

## Timing
- Reset values: busy=0, done=0, c=3'b000, counter=0, shift registers=0.
- Cycle numbering: start sampled at edge 0.
  - busy is high from after edge 0.
  - Digit i (i=0 is the MSB digit) is examined in the cycle after edge i.
  - The result registers at edge i+1; done and c are visible in the following cycle.
- Latency from start edge to done edge:
  - minimum 1 cycle (first digit differs);
  - maximum WIDTH/DIGIT cycles (operands equal or differ in the last digit).
- busy falls at the same edge where done rises.
- Back-to-back: start asserted in the done cycle is accepted, with no bubble.
- DIGIT=WIDTH degenerates to a single-cycle registered comparator (latency 1).

## Structure
- Shared package comparator_pkg holds:
  - the state enum (IDLE, CMP);
  - result index constants C_GT=2, C_EQ=1, C_LT=0;
  - result literals RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001, RES_NONE=3'b000.
- One sub-module, digit_compare: a combinational DIGIT-bit unsigned compare producing gt and lt. The top level instantiates it once on the top digits of sa and sb.
- Counter width is $clog2(WIDTH/DIGIT), minimum 1.

## Test plan
Default configuration WIDTH=8, DIGIT=2.
- Equal operands: a=8'hA5, b=8'hA5, unsigned, start -> busy for 4 cycles; done at edge 4; c=3'b010.
- Early termination with mode dependence: a=8'h80, b=8'h7F.
  - Unsigned -> done at edge 1, c=3'b100.
  - Repeated with signed_mode=1 -> done at edge 1, c=3'b001.
- Last-digit difference: a=8'h12, b=8'h13, unsigned -> done at edge 4, c=3'b001. Then a=8'hFE, b=8'hFF, signed -> c=3'b001.
- Handshake:
  - a second start pulse while busy is ignored, and c reflects only the first operands;
  - start in the done cycle with a=8'h01, b=8'h00 -> next done at edge 4 of that compare, c=3'b100.
- Reset mid-operation: drive rst_n low asynchronously in cycle 2 of an equal-operand compare -> busy, done and c drop to 0 immediately; no done pulse after release; the next start behaves normally.
- Exhaustive check at WIDTH=2, DIGIT=1 and at WIDTH=2, DIGIT=2: all 16 (a,b) pairs in both modes. Each c must match a reference model, and each latency must match the first-differing-digit rule.
